// File: rtl/rr_route_arbiter_pkg.sv
// rr_route_arbiter_pkg
// Shared constants and helpers for the round-robin route arbiter between the
// four input FIFOs and the four output FIFOs of the PCIe layer.
//   NUM_FIFOS   : FIFOs per bank
//   DEST_W      : width of the destination field at the top of each word
//   DEST_MSB    : destination MSB for the default 10-bit word
//   get_dest    : extract the destination index of a word given its MSB position
//   to_onehot   : index -> one-hot strobe
//   from_onehot : one-hot strobe -> index
package rr_route_arbiter_pkg;

    localparam int NUM_FIFOS         = 4;
    localparam int DEST_W            = 2;
    localparam int DEFAULT_WORD_SIZE = 10;
    localparam int DEST_MSB          = DEFAULT_WORD_SIZE - 1;

    typedef logic [DEST_W-1:0]    fifo_idx_t;
    typedef logic [NUM_FIFOS-1:0] fifo_mask_t;

    // The word is passed zero-extended so one helper serves any WORD_SIZE.
    function automatic fifo_idx_t get_dest(input logic [63:0] word, input int msb);
        return DEST_W'(word >> (msb - DEST_W + 1));
    endfunction

    function automatic fifo_mask_t to_onehot(input fifo_idx_t idx);
        return NUM_FIFOS'(1) << idx;
    endfunction

    function automatic fifo_idx_t from_onehot(input fifo_mask_t oh);
        fifo_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (oh[i]) begin
                idx = DEST_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_route_arbiter_rr_pick.sv
// rr_pick
// Combinational 4-way round-robin picker. The search starts one past the
// last granted index and wraps; the first requester found wins.
//   req     : request mask
//   ptr     : index of the last grant
//   gnt     : one-hot grant (zero when nobody requests)
//   gnt_idx : index of the grant (equals ptr when nothing is granted)
//   any     : a grant was made
module rr_pick
    import rr_route_arbiter_pkg::*;
(
    input  logic [NUM_FIFOS-1:0] req,
    input  logic [DEST_W-1:0]    ptr,
    output logic [NUM_FIFOS-1:0] gnt,
    output logic [DEST_W-1:0]    gnt_idx,
    output logic                 any
);

    logic [DEST_W-1:0] cand;

    // Offset k = 1..4 visits ptr+1, ptr+2, ptr+3 and finally ptr itself, so
    // a lone requester sitting at ptr is still granted every cycle.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        any     = 1'b0;
        cand    = ptr;
        for (int k = 1; k <= NUM_FIFOS; k++) begin
            cand = ptr + DEST_W'(k);
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt     = to_onehot(cand);
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_route_arbiter.sv
// rr_route_arbiter
// Round-robin scheduler moving words from input FIFOs 1..4 to output FIFOs
// 5..8. At most one pop per cycle; the word's top two bits select the output
// FIFO. Pop-to-push latency is two cycles (one for the FIFO read, one for the
// output register).
// Optional feature macro: ARB_STALL_CNT_EN adds a saturating stall counter.
// Ports:
//   clk, reset_L     : clock, asynchronous active-low reset
//   active           : layer FSM is ACTIVE; low blocks new pops
//   in_empty         : input FIFO empty flags
//   in_data          : input FIFO read data, slice i belongs to input i
//   out_almost_full  : output FIFO almost_full flags
//   in_rd            : one-hot pop strobe
//   out_wr           : one-hot push strobe
//   out_data         : word pushed to the output bank
//   busy             : a word is in flight
//   stall_cnt        : (ARB_STALL_CNT_EN only) cycles blocked by almost_full
module rr_route_arbiter
    import rr_route_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = 10,
    parameter int FIFO_UNITS = 4
)
(
    input  logic                            clk,
    input  logic                            reset_L,
    input  logic                            active,
    input  logic [FIFO_UNITS-1:0]           in_empty,
    input  logic [FIFO_UNITS*WORD_SIZE-1:0] in_data,
    input  logic [FIFO_UNITS-1:0]           out_almost_full,
    output logic [FIFO_UNITS-1:0]           in_rd,
    output logic [FIFO_UNITS-1:0]           out_wr,
    output logic [WORD_SIZE-1:0]            out_data,
    output logic                            busy
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [7:0]                      stall_cnt
`endif
);

    logic [DEST_W-1:0]    ptr;
    logic [DEST_W-1:0]    g1;
    logic                 v1;
    logic [NUM_FIFOS-1:0] eligible;
    logic [NUM_FIFOS-1:0] gnt;
    logic [DEST_W-1:0]    gnt_idx;
    logic                 any_gnt;
    logic [WORD_SIZE-1:0] cur_word;

    // The destination is unknown until the word is read, so any almost_full
    // blocks every pop; the output thresholds leave room for two in-flight words.
    assign eligible = (active && out_almost_full == '0) ? ~in_empty : '0;

    rr_pick u_pick (
        .req     (eligible),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_gnt)
    );

    // Gated by reset so a pop strobe cannot leak out while reset is held.
    assign in_rd = reset_L ? gnt : '0;

    assign cur_word = WORD_SIZE'(in_data >> (32'(g1) * WORD_SIZE));

    // Stage 1 remembers which FIFO was popped; stage 2 registers that FIFO's
    // data (valid one cycle after the pop) and strobes the addressed output.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr      <= 2'd3;
            g1       <= '0;
            v1       <= 1'b0;
            out_wr   <= '0;
            out_data <= '0;
        end else begin
            v1 <= any_gnt;
            if (any_gnt) begin
                ptr <= gnt_idx;
                g1  <= gnt_idx;
            end
            if (v1) begin
                out_wr   <= to_onehot(get_dest(64'(cur_word), WORD_SIZE - 1));
                out_data <= cur_word;
            end else begin
                out_wr <= '0;
            end
        end
    end

    assign busy = v1 | (|out_wr);

`ifdef ARB_STALL_CNT_EN
    // Counts cycles where data is waiting but almost_full holds it back.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            stall_cnt <= '0;
        end else if (active && !(&in_empty) && (|out_almost_full) && stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_route_arbiter.sv
// tb_rr_route_arbiter
// Self-checking bench for rr_route_arbiter. Input FIFOs are modelled as
// queues with one-cycle read latency; a reference model decides each cycle's
// grant from the round-robin rule and queues the expected push, which a
// separate monitor compares when the DUT strobes out_wr.
module tb_rr_route_arbiter;

    localparam int W = 10;

    typedef struct {
        logic [W-1:0] word;
        logic [3:0]   wr;
        int           due;
    } exp_t;

    logic           clk;
    logic           reset_L;
    logic           active;
    logic [3:0]     in_empty;
    logic [4*W-1:0] in_data;
    logic [3:0]     out_almost_full;
    logic [3:0]     in_rd;
    logic [3:0]     out_wr;
    logic [W-1:0]   out_data;
    logic           busy;
`ifdef ARB_STALL_CNT_EN
    logic [7:0]     stall_cnt;
`endif

    logic [W-1:0] q [4][$];
    logic [W-1:0] in_word [4];
    exp_t         sb [$];
    int           cyc;
    int           checks;
    int           errors;
    int           mptr;
    int           mstall;
    logic [3:0]   af_state;

    rr_route_arbiter #(.WORD_SIZE(W), .FIFO_UNITS(4)) dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .active          (active),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .out_almost_full (out_almost_full),
        .in_rd           (in_rd),
        .out_wr          (out_wr),
        .out_data        (out_data),
        .busy            (busy)
`ifdef ARB_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input FIFO model: a pop presents the head word on the next cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (in_rd[i] && q[i].size() > 0) begin
                in_word[i] <= q[i].pop_front();
            end
        end
    end

    assign in_data = {in_word[3], in_word[2], in_word[1], in_word[0]};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic pushWord(input int i, input logic [W-1:0] w);
        q[i].push_back(w);
    endtask

    // Reference model for one cycle: grant rule, scoreboard push, stall count.
    task automatic modelStep();
        int          grant;
        int          idx;
        logic [3:0]  exp_rd;
        exp_t        e;
        grant = -1;
        if (active && out_almost_full == 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (mptr + k) % 4;
                if (grant < 0 && q[idx].size() > 0) grant = idx;
            end
        end
        exp_rd = (grant >= 0) ? 4'(1 << grant) : 4'b0000;
        checkOutput("in_rd", 32'(in_rd), 32'(exp_rd));
        if (grant >= 0) begin
            e.word = q[grant][0];
            e.wr   = 4'(1 << (int'(e.word) / (1 << (W - 2))));
            e.due  = cyc + 2;
            sb.push_back(e);
            mptr = grant;
        end
        if (active && in_empty != 4'hF && out_almost_full != 4'h0 && mstall < 255) begin
            mstall++;
        end
    endtask

    // One cycle: apply inputs at the falling edge, optionally pulse reset,
    // then run the model against the settled combinational grant.
    task automatic applyStimulus(input bit act, input logic [3:0] af, input bit do_reset);
        @(negedge clk);
        active          = do_reset ? 1'b0 : act;
        out_almost_full = af;
        for (int i = 0; i < 4; i++) in_empty[i] = (q[i].size() == 0);
        if (do_reset) begin
            reset_L = 1'b0;
            #1;
            checkOutput("rst_in_rd", 32'(in_rd), 32'h0);
            checkOutput("rst_out_wr", 32'(out_wr), 32'h0);
            checkOutput("rst_out_data", 32'(out_data), 32'h0);
            checkOutput("rst_busy", 32'(busy), 32'h0);
            sb.delete();
            mptr    = 3;
            mstall  = 0;
            reset_L = 1'b1;
        end else begin
            #1;
        end
        modelStep();
    endtask

    function automatic bit queuesEmpty();
        for (int i = 0; i < 4; i++) if (q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor: compares every push with the scoreboard head, and flags a
    // push that is overdue or unexpected.
    initial begin
        exp_t e;
        bit   busy_exp;
        forever begin
            @(negedge clk);
            #2;
            busy_exp = 1'b0;
            foreach (sb[j]) if (sb[j].due == cyc || sb[j].due == cyc + 1) busy_exp = 1'b1;
            checkOutput("busy", 32'(busy), 32'(busy_exp));
            if (out_wr != 4'b0000) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_push", 32'(out_wr), 32'h0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("push_cycle", 32'(cyc), 32'(e.due));
                    checkOutput("out_wr", 32'(out_wr), 32'(e.wr));
                    checkOutput("out_data", 32'(out_data), 32'(e.word));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                checkOutput("missing_push", 32'(out_wr), 32'(sb[0].wr));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] pattern [4];
        pattern = '{10'h0FF, 10'h1EE, 10'h2DD, 10'h3CC};
        checks          = 0;
        errors          = 0;
        mptr            = 3;
        mstall          = 0;
        af_state        = 4'b0000;
        reset_L         = 1'b0;
        active          = 1'b0;
        out_almost_full = 4'b0000;
        in_empty        = 4'hF;
        for (int i = 0; i < 4; i++) in_word[i] = '0;

        // Reset held with the clock running.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_in_rd", 32'(in_rd), 32'h0);
        checkOutput("reset_out_wr", 32'(out_wr), 32'h0);
        checkOutput("reset_out_data", 32'(out_data), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        reset_L = 1'b1;

        // Single word on input 0: first grant after reset must be input 0.
        pushWord(0, 10'h2DD);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("first_grant", 32'(in_rd), 32'h1);
        repeat (4) applyStimulus(1'b1, 4'b0000, 1'b0);

        // Two words per input, full rotation with no idle cycles.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) pushWord(i, pattern[i]);
        repeat (12) applyStimulus(1'b1, 4'b0000, 1'b0);

        // Random traffic with almost_full bursts.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 1) == 1 && q[i].size() < 6) pushWord(i, W'($urandom_range(0, 1023)));
            if ($urandom_range(0, 7) == 0)
                af_state = (af_state != 4'b0000) ? 4'b0000 : 4'($urandom_range(1, 15));
            applyStimulus(1'b1, af_state, 1'b0);
        end

        // Active drops with traffic pending: in-flight words still arrive.
        for (int i = 0; i < 4; i++) pushWord(i, W'($urandom_range(0, 1023)));
        repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0);
        repeat (6) applyStimulus(1'b0, 4'b0000, 1'b0);

        // Reset pulse with words in flight: they are discarded.
        for (int i = 0; i < 4; i++) pushWord(i, W'($urandom_range(0, 1023)));
        repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        repeat (4) applyStimulus(1'b1, 4'b0000, 1'b0);

`ifdef ARB_STALL_CNT_EN
        pushWord(0, 10'h155);
        repeat (300) applyStimulus(1'b1, 4'b0010, 1'b0);
        checkOutput("stall_cnt_model", 32'(stall_cnt), 32'(mstall));
        checkOutput("stall_cnt_sat", 32'(stall_cnt), 32'd255);
`endif

        // Drain whatever is left.
        for (int n = 0; n < 200 && (!queuesEmpty() || sb.size() > 0); n++)
            applyStimulus(1'b1, 4'b0000, 1'b0);
        repeat (3) applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("drain_queue", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
